// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score engine.
// A 2-digit BCD point constant is widened to the largest supported score width.
package score_pkg;

    typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] BCD_NINE   = 4'd9;
    localparam int         MAX_DIGITS = 8;

    function automatic logic [BCD_W*MAX_DIGITS-1:0] pack_bcd2(input logic [7:0] value);
        return {{(BCD_W*MAX_DIGITS-8){1'b0}}, value};
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder: a + b + cin with decimal carry out.
module bcd_digit_add
    import score_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    output logic [BCD_W-1:0] sum,
    output logic             cout
);

    logic [BCD_W:0] raw;
    logic [BCD_W:0] adjusted;

    always_comb begin
        raw      = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
        adjusted = raw - (BCD_W+1)'(10);
        if (raw > {1'b0, BCD_NINE}) begin
            sum  = adjusted[BCD_W-1:0];
            cout = 1'b1;
        end else begin
            sum  = raw[BCD_W-1:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_score_engine.sv
// Serial N-digit BCD score keeper with queued eat/bonus events and atomic commit.
// Optional high-score register enabled by defining SCORE_HISCORE_EN.
module bcd_score_engine
    import score_pkg::*;
#(
    parameter int         DIGITS      = 4,
    parameter logic [7:0] EAT_PTS     = 8'h01,
    parameter logic [7:0] BONUS_PTS   = 8'h25,
    parameter int         PEND_W      = 3,
    parameter bit         SATURATE    = 1'b1,
    parameter int         LEVEL_DIGIT = 1
) (
    input  logic                      clk_pix,
    input  logic                      reset_n,
    input  logic                      eat_evt,
    input  logic                      bonus_evt,
    input  logic                      clear,
    output logic [BCD_W*DIGITS-1:0]   score,
    output logic [BCD_W*DIGITS-1:0]   hi_score,
    output logic                      busy,
    output logic                      level_up,
    output logic                      new_hi,
    output logic                      ovf,
    output logic                      dropped
);

    localparam int W     = BCD_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int LVL_LO = LEVEL_DIGIT * BCD_W;

    localparam logic [IDX_W-1:0]            LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic [BCD_W*MAX_DIGITS-1:0] EAT_FULL   = pack_bcd2(EAT_PTS);
    localparam logic [BCD_W*MAX_DIGITS-1:0] BONUS_FULL = pack_bcd2(BONUS_PTS);
    localparam logic [W-1:0]                EAT_ADD    = EAT_FULL[W-1:0];
    localparam logic [W-1:0]                BONUS_ADD  = BONUS_FULL[W-1:0];
    localparam logic [W-1:0]                ALL_NINES  = {DIGITS{BCD_NINE}};
    localparam logic [PEND_W-1:0]           PEND_MAX   = '1;

    state_t            state;
    state_t            state_next;
    logic [W-1:0]      work;
    logic [W-1:0]      addend;
    logic [W-1:0]      commit_val;
    logic [IDX_W-1:0]  idx;
    logic              carry;
    logic [PEND_W-1:0] pend_eat;
    logic [PEND_W-1:0] pend_bonus;
    logic              load_eat;
    logic              load_bonus;
    logic [BCD_W-1:0]  work_digit;
    logic [BCD_W-1:0]  add_digit;
    logic [BCD_W-1:0]  digit_sum;
    logic              digit_carry;

    assign work_digit = work[idx*BCD_W +: BCD_W];
    assign add_digit  = addend[idx*BCD_W +: BCD_W];
    assign commit_val = (carry && SATURATE) ? ALL_NINES : work;
    assign busy       = (state != IDLE) || (pend_eat != '0) || (pend_bonus != '0);

    bcd_digit_add u_digit_add (
        .a    (work_digit),
        .b    (add_digit),
        .cin  (carry),
        .sum  (digit_sum),
        .cout (digit_carry)
    );

    always_ff @(posedge clk_pix) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_eat   = 1'b0;
        load_bonus = 1'b0;
        case (state)
            IDLE: begin
                if (pend_bonus != '0) begin
                    load_bonus = 1'b1;
                    state_next = ADD;
                end else if (pend_eat != '0) begin
                    load_eat   = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                if (idx == LAST_IDX) begin
                    state_next = COMMIT;
                end
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
            load_eat   = 1'b0;
            load_bonus = 1'b0;
        end
    end

    // An event landing in the cycle its counter is consumed cancels out.
    always_ff @(posedge clk_pix) begin
        if (!reset_n || clear) begin
            pend_eat   <= '0;
            pend_bonus <= '0;
            dropped    <= 1'b0;
        end else begin
            if (eat_evt && !load_eat) begin
                if (pend_eat == PEND_MAX) begin
                    dropped <= 1'b1;
                end else begin
                    pend_eat <= pend_eat + 1'b1;
                end
            end else if (!eat_evt && load_eat) begin
                pend_eat <= pend_eat - 1'b1;
            end
            if (bonus_evt && !load_bonus) begin
                if (pend_bonus == PEND_MAX) begin
                    dropped <= 1'b1;
                end else begin
                    pend_bonus <= pend_bonus + 1'b1;
                end
            end else if (!bonus_evt && load_bonus) begin
                pend_bonus <= pend_bonus - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!reset_n || clear) begin
            work     <= '0;
            addend   <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            score    <= '0;
            ovf      <= 1'b0;
            level_up <= 1'b0;
        end else begin
            level_up <= 1'b0;
            if (load_bonus || load_eat) begin
                work   <= score;
                addend <= load_bonus ? BONUS_ADD : EAT_ADD;
                idx    <= '0;
                carry  <= 1'b0;
            end else if (state == ADD) begin
                work[idx*BCD_W +: BCD_W] <= digit_sum;
                carry <= digit_carry;
                idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else if (state == COMMIT) begin
                work     <= commit_val;
                score    <= commit_val;
                level_up <= (commit_val[W-1:LVL_LO] != score[W-1:LVL_LO]);
                if (carry) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

`ifdef SCORE_HISCORE_EN
    // Packed BCD orders the same as unsigned binary, so a plain compare suffices.
    always_ff @(posedge clk_pix) begin
        if (!reset_n) begin
            hi_score <= '0;
            new_hi   <= 1'b0;
        end else begin
            new_hi <= 1'b0;
            if (!clear && state == COMMIT && commit_val > hi_score) begin
                hi_score <= commit_val;
                new_hi   <= 1'b1;
            end
        end
    end
`else
    assign hi_score = '0;
    assign new_hi   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_score_engine.sv
// Directed bench for bcd_score_engine: a vector table on a 4-digit instance plus
// hand-written sequences for latency, clear, overflow and pending saturation.
module tb_bcd_score_engine;

`ifdef SCORE_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    logic clk_pix = 1'b0;
    logic reset_n = 1'b0;

    logic        eat_a = 0, bonus_a = 0, clear_a = 0;
    logic [15:0] score_a, hi_a;
    logic        busy_a, level_up_a, new_hi_a, ovf_a, dropped_a;

    logic        eat_b = 0, bonus_b = 0, clear_b = 0;
    logic [7:0]  score_b, hi_b, score_c, hi_c;
    logic        busy_b, level_up_b, new_hi_b, ovf_b, dropped_b;
    logic        busy_c, level_up_c, new_hi_c, ovf_c, dropped_c;

    logic        eat_d = 0, bonus_d = 0, clear_d = 0;
    logic [15:0] score_d, hi_d;
    logic        busy_d, level_up_d, new_hi_d, ovf_d, dropped_d;

    int checks   = 0;
    int failures = 0;
    int lvl_a    = 0;
    int newhi_a  = 0;

    always #5 clk_pix = ~clk_pix;

    bcd_score_engine #(.DIGITS(4), .PEND_W(4)) dut_a (
        .clk_pix(clk_pix), .reset_n(reset_n), .eat_evt(eat_a), .bonus_evt(bonus_a),
        .clear(clear_a), .score(score_a), .hi_score(hi_a), .busy(busy_a),
        .level_up(level_up_a), .new_hi(new_hi_a), .ovf(ovf_a), .dropped(dropped_a));

    bcd_score_engine #(.DIGITS(2), .PEND_W(3), .SATURATE(1'b1)) dut_b (
        .clk_pix(clk_pix), .reset_n(reset_n), .eat_evt(eat_b), .bonus_evt(bonus_b),
        .clear(clear_b), .score(score_b), .hi_score(hi_b), .busy(busy_b),
        .level_up(level_up_b), .new_hi(new_hi_b), .ovf(ovf_b), .dropped(dropped_b));

    bcd_score_engine #(.DIGITS(2), .PEND_W(3), .SATURATE(1'b0)) dut_c (
        .clk_pix(clk_pix), .reset_n(reset_n), .eat_evt(eat_b), .bonus_evt(bonus_b),
        .clear(clear_b), .score(score_c), .hi_score(hi_c), .busy(busy_c),
        .level_up(level_up_c), .new_hi(new_hi_c), .ovf(ovf_c), .dropped(dropped_c));

    bcd_score_engine #(.DIGITS(4), .PEND_W(2)) dut_d (
        .clk_pix(clk_pix), .reset_n(reset_n), .eat_evt(eat_d), .bonus_evt(bonus_d),
        .clear(clear_d), .score(score_d), .hi_score(hi_d), .busy(busy_d),
        .level_up(level_up_d), .new_hi(new_hi_d), .ovf(ovf_d), .dropped(dropped_d));

    always @(negedge clk_pix) begin
        if (level_up_a) lvl_a++;
        if (new_hi_a)   newhi_a++;
    end

    typedef struct {
        int          n_eat;
        int          n_bonus;
        logic [15:0] exp_score;
        int          exp_lvl;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pulse(input int sel, input bit e, input bit b, input bit c);
        @(negedge clk_pix);
        case (sel)
            0:       begin eat_a = e; bonus_a = b; clear_a = c; end
            1:       begin eat_b = e; bonus_b = b; clear_b = c; end
            default: begin eat_d = e; bonus_d = b; clear_d = c; end
        endcase
        @(negedge clk_pix);
        case (sel)
            0:       begin eat_a = 0; bonus_a = 0; clear_a = 0; end
            1:       begin eat_b = 0; bonus_b = 0; clear_b = 0; end
            default: begin eat_d = 0; bonus_d = 0; clear_d = 0; end
        endcase
    endtask

    task automatic wait_idle(input int sel, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_pix);
            case (sel)
                0:       done = !busy_a;
                1:       done = !busy_b && !busy_c;
                default: done = !busy_d;
            endcase
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s idle timeout actual=busy required=idle", name);
        end
        repeat (2) @(negedge clk_pix);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk_pix);
        reset_n = 1'b1;
        @(negedge clk_pix);
    endtask

    initial begin
        int  lvl0;
        int  nh0;
        bit  seen;

        vecs[0] = '{n_eat: 1, n_bonus: 0, exp_score: 16'h0001, exp_lvl: 0};
        vecs[1] = '{n_eat: 0, n_bonus: 1, exp_score: 16'h0026, exp_lvl: 1};
        vecs[2] = '{n_eat: 3, n_bonus: 0, exp_score: 16'h0029, exp_lvl: 0};
        vecs[3] = '{n_eat: 1, n_bonus: 0, exp_score: 16'h0030, exp_lvl: 1};
        vecs[4] = '{n_eat: 0, n_bonus: 4, exp_score: 16'h0130, exp_lvl: 4};
        vecs[5] = '{n_eat: 1, n_bonus: 1, exp_score: 16'h0156, exp_lvl: 1};
        vecs[6] = '{n_eat: 2, n_bonus: 3, exp_score: 16'h0233, exp_lvl: 3};

        // Reset state
        repeat (3) @(negedge clk_pix);
        check("reset score", score_a, 16'h0000);
        check("reset hi", hi_a, 16'h0000);
        check("reset flags", {busy_a, level_up_a, new_hi_a, ovf_a, dropped_a}, 5'b0);
        reset_n = 1'b1;
        @(negedge clk_pix);

        // Single eat: latency of DIGITS+2 edges
        lvl0 = lvl_a;
        pulse(0, 1, 0, 0);
        check("single busy", busy_a, 1'b1);
        repeat (5) @(negedge clk_pix);
        check("single score early", score_a, 16'h0000);
        @(negedge clk_pix);
        check("single score", score_a, 16'h0001);
        wait_idle(0, "single");
        check("single level_up", lvl_a - lvl0, 0);

        // Table of event bursts on a cleared score
        pulse(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            lvl0 = lvl_a;
            for (int j = 0; j < vecs[i].n_bonus; j++) pulse(0, 0, 1, 0);
            for (int j = 0; j < vecs[i].n_eat; j++)   pulse(0, 1, 0, 0);
            wait_idle(0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d score", i), score_a, vecs[i].exp_score);
            check($sformatf("vec%0d level_up", i), lvl_a - lvl0, vecs[i].exp_lvl);
            check($sformatf("vec%0d ovf", i), ovf_a, 1'b0);
            check($sformatf("vec%0d hi", i), hi_a, HI_EN ? vecs[i].exp_score : 16'h0000);
        end

        // Ten consecutive eats
        pulse(0, 0, 0, 1);
        lvl0 = lvl_a;
        @(negedge clk_pix);
        eat_a = 1'b1;
        repeat (10) @(negedge clk_pix);
        eat_a = 1'b0;
        wait_idle(0, "ten eats");
        check("ten score", score_a, 16'h0010);
        check("ten level_up", lvl_a - lvl0, 1);
        check("ten dropped", dropped_a, 1'b0);

        // Simultaneous eat and bonus: bonus commits first
        pulse(0, 0, 0, 1);
        pulse(0, 1, 1, 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_pix);
            seen = (score_a != 16'h0000);
        end
        check("both first score", score_a, 16'h0025);
        check("both first busy", busy_a, 1'b1);
        wait_idle(0, "both");
        check("both final score", score_a, 16'h0026);
        check("both final busy", busy_a, 1'b0);

        // Clear mid-add keeps high score and discards coincident events
        do_reset();
        nh0 = newhi_a;
        pulse(0, 0, 1, 0);
        wait_idle(0, "hi setup");
        check("hi setup score", score_a, 16'h0025);
        check("hi setup new_hi", newhi_a - nh0, HI_EN ? 1 : 0);
        nh0 = newhi_a;
        pulse(0, 1, 0, 0);
        repeat (2) @(negedge clk_pix);
        pulse(0, 1, 1, 1);
        check("clear score", score_a, 16'h0000);
        check("clear busy", busy_a, 1'b0);
        check("clear flags", {ovf_a, dropped_a}, 2'b00);
        pulse(0, 1, 0, 0);
        wait_idle(0, "after clear");
        check("after clear score", score_a, 16'h0001);
        check("after clear hi", hi_a, HI_EN ? 16'h0025 : 16'h0000);
        check("after clear new_hi", newhi_a - nh0, 0);

        // Two-digit overflow: saturate vs wrap
        for (int i = 0; i < 99; i++) begin
            pulse(1, 1, 0, 0);
            wait_idle(1, "fill 99");
        end
        check("99 sat score", score_b, 8'h99);
        check("99 wrap score", score_c, 8'h99);
        check("99 ovf", {ovf_b, ovf_c}, 2'b00);
        pulse(1, 1, 0, 0);
        wait_idle(1, "overflow");
        check("sat score", score_b, 8'h99);
        check("sat ovf", ovf_b, 1'b1);
        check("wrap score", score_c, 8'h00);
        check("wrap ovf", ovf_c, 1'b1);
        pulse(1, 0, 0, 1);
        check("ovf clear", {ovf_b, ovf_c}, 2'b00);
        check("ovf clear score", {score_b, score_c}, 16'h0000);

        // Pending counter saturation with PEND_W=2
        @(negedge clk_pix);
        eat_d = 1'b1;
        repeat (5) @(negedge clk_pix);
        eat_d = 1'b0;
        wait_idle(2, "drop");
        check("drop score", score_d, 16'h0004);
        check("drop flag", dropped_d, 1'b1);
        pulse(2, 0, 0, 1);
        check("drop clear", dropped_d, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
